// File: rtl/soc_mem_arb_pkg.sv
// Shared types for the instruction SRAM port arbiter: port index and lock FSM states.
package soc_mem_arb_pkg;

    // Largest supported requester count; the port index is sized to cover it.
    localparam int MAX_REQ    = 4;
    localparam int PORT_IDX_W = (MAX_REQ > 1) ? $clog2(MAX_REQ) : 1;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_owner_fifo.sv
// Owner FIFO: remembers which port issued each accepted SRAM transaction, in order.
module arb_owner_fifo
    import soc_mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_push,
    input  port_idx_t i_idx,
    input  logic      i_pop,
    output logic      o_full,
    output logic      o_empty,
    output port_idx_t o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    port_idx_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage write; contents are don't-care while empty so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_idx;
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= ptr_inc(r_wptr);
            if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/inst_sram_port_arbiter.sv
// Single-port instruction SRAM arbiter: starvation-aware priority, lock while a
// request waits for grant, and in-order response routing via the owner FIFO.
module inst_sram_port_arbiter
    import soc_mem_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int MAX_WAIT        = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_ni,
    input  logic [NUM_REQ-1:0]                   req_i,
    input  logic [NUM_REQ-1:0]                   we_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]                   gnt_o,
    output logic [NUM_REQ-1:0]                   rvalid_o,
    output logic [DATA_WIDTH-1:0]                rdata_o,
    output logic                                 mem_req_o,
    output logic                                 mem_we_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic [DATA_WIDTH/8-1:0]              mem_be_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    input  logic                                 mem_gnt_i,
    input  logic                                 mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
    output logic                                 err_o
);

    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int WCNT_W = $clog2(MAX_WAIT + 1);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    port_idx_t  r_lock_idx;
    port_idx_t  w_lock_nxt;
    logic       r_err;

    logic [NUM_REQ-1:0][WCNT_W-1:0] r_wait_cnt;
    logic [NUM_REQ-1:0]             w_starved;

    port_idx_t              w_pick_idx;
    port_idx_t              w_sel_idx;
    logic                   w_sel_req;
    logic                   w_sel_we;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [BE_W-1:0]        w_sel_be;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;

    logic      w_mem_req;
    logic      w_push;
    logic      w_pop;
    logic      w_full;
    logic      w_empty;
    port_idx_t w_head;

    // A port is starved once it has waited MAX_WAIT cycles while requesting.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_starve
        assign w_starved[g] = req_i[g] && (r_wait_cnt[g] == WCNT_W'(MAX_WAIT));
    end

    // Winner in IDLE: lowest starved port, otherwise lowest requesting port.
    always_comb begin
        w_pick_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) w_pick_idx = port_idx_t'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_starved[i]) w_pick_idx = port_idx_t'(i);
        end
    end

    // While LOCKED the latched port is forwarded so the command cannot change before grant.
    assign w_sel_idx = (r_state == ST_LOCKED) ? r_lock_idx : w_pick_idx;

    // Command mux from the selected port.
    always_comb begin
        w_sel_req   = 1'b0;
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_be    = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel_idx == port_idx_t'(i)) begin
                w_sel_req   = req_i[i];
                w_sel_we    = we_i[i];
                w_sel_addr  = addr_i[i];
                w_sel_be    = be_i[i];
                w_sel_wdata = wdata_i[i];
            end
        end
    end

    // Reset gates the request path so every output reads 0 the moment reset asserts,
    // even if requesters are still holding req. A full FIFO blocks issue outright;
    // a same-cycle pop does not reopen it, keeping the issue path off the rvalid path.
    assign w_mem_req = w_sel_req & ~w_full & reset_ni;
    assign w_push    = w_mem_req & mem_gnt_i;
    assign w_pop     = mem_rvalid_i & ~w_empty;

    assign mem_req_o   = w_mem_req;
    assign mem_we_o    = w_mem_req & w_sel_we;
    assign mem_addr_o  = w_mem_req ? w_sel_addr  : '0;
    assign mem_be_o    = w_mem_req ? w_sel_be    : '0;
    assign mem_wdata_o = w_mem_req ? w_sel_wdata : '0;

    // Grant and response decode; rdata is zeroed when no response is routed.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_route
        assign gnt_o[g]    = w_push && (w_sel_idx == port_idx_t'(g));
        assign rvalid_o[g] = w_pop && (w_head == port_idx_t'(g));
    end
    assign rdata_o = w_pop ? mem_rdata_i : '0;
    assign err_o   = r_err;

    // Per-port wait counter: counts ungranted request cycles, saturating at MAX_WAIT.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_wait
        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                r_wait_cnt[g] <= '0;
            end else if (gnt_o[g]) begin
                r_wait_cnt[g] <= '0;
            end else if (req_i[g] && (r_wait_cnt[g] != WCNT_W'(MAX_WAIT))) begin
                r_wait_cnt[g] <= r_wait_cnt[g] + WCNT_W'(1);
            end
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= ST_IDLE;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_idx <= w_lock_nxt;
        end
    end

    // Lock FSM next state: latch the winner when the SRAM stalls, release on grant.
    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_req && !mem_gnt_i) begin
                    w_state_nxt = ST_LOCKED;
                    w_lock_nxt  = w_pick_idx;
                end
            end
            ST_LOCKED: begin
                if (mem_gnt_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sticky error on a response with nothing outstanding; that response is dropped.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)                     r_err <= 1'b0;
        else if (mem_rvalid_i && w_empty)  r_err <= 1'b1;
    end

    arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .i_clk   (clk_i),
        .i_rst_n (reset_ni),
        .i_push  (w_push),
        .i_idx   (w_sel_idx),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

endmodule

// File: tb/tb_inst_sram_port_arbiter.sv
// Randomized scoreboard bench for inst_sram_port_arbiter with directed scenarios.
module tb_inst_sram_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;
    localparam int MW = 8;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NR-1:0]            req = '0;
    logic [NR-1:0]            we = '0;
    logic [NR-1:0][AW-1:0]    addr = '0;
    logic [NR-1:0][DW/8-1:0]  be = '0;
    logic [NR-1:0][DW-1:0]    wdata = '0;
    logic [NR-1:0]            gnt_o;
    logic [NR-1:0]            rvalid_o;
    logic [DW-1:0]            rdata_o;
    logic                     mem_req_o, mem_we_o;
    logic [AW-1:0]            mem_addr_o;
    logic [DW/8-1:0]          mem_be_o;
    logic [DW-1:0]            mem_wdata_o;
    logic                     mem_gnt_i = 1'b0;
    logic                     mem_rvalid_i = 1'b0;
    logic [DW-1:0]            mem_rdata_i = '0;
    logic                     err_o;

    inst_sram_port_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MAX_OUTSTANDING(MO), .MAX_WAIT(MW)
    ) dut (
        .clk_i(clk), .reset_ni(rst_n),
        .req_i(req), .we_i(we), .addr_i(addr), .be_i(be), .wdata_i(wdata),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct { int port; logic [DW-1:0] data; } exp_t;
    typedef struct { int due;  logic [DW-1:0] data; } rsp_t;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    exp_t exp_q[$];
    rsp_t s_q[$];
    logic [NR-1:0] g_hist[$];

    // Requesters
    bit              rq_act [NR];
    logic            rq_we  [NR];
    logic [AW-1:0]   rq_addr[NR];
    logic [DW/8-1:0] rq_be  [NR];
    logic [DW-1:0]   rq_wd  [NR];

    // Reference model state (spec-level view of the arbiter)
    int  m_wait[NR];
    bit  m_locked;
    int  m_lock;
    int  m_out;
    bit  m_err;
    logic [DW-1:0] m_img[logic [AW-1:0]];

    // SRAM environment
    logic [DW-1:0] s_img[logic [AW-1:0]];
    int  cyc = 0;
    bit  spurious = 1'b0;

    // Knobs
    int req_pct = 0, gnt_pct = 100, dly_min = 1, dly_max = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [DW/8-1:0] b);
        logic [DW-1:0] r;
        r = o;
        for (int k = 0; k < DW/8; k++) if (b[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    task automatic issue(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [DW/8-1:0] b, input logic [DW-1:0] d);
        rq_act[p] = 1'b1; rq_we[p] = w; rq_addr[p] = a; rq_be[p] = b; rq_wd[p] = d;
    endtask

    task automatic issue_rand(input int p);
        logic w;
        w = ($urandom_range(0, 3) == 0);
        issue(p, w, {24'h0, 6'($urandom_range(0, 63)), 2'b00},
              w ? 4'($urandom_range(1, 15)) : 4'hF, $urandom());
    endtask

    // One clock cycle: drive, predict, compare, then advance model and environment.
    task automatic step();
        int cand;
        bit full, ex_mreq, hs, rv, rv_q;
        logic [NR-1:0] ex_gnt;
        logic [DW-1:0] old, d;
        logic hs_we;
        logic [AW-1:0] hs_addr;
        logic [DW/8-1:0] hs_be;
        logic [DW-1:0] hs_wd;
        int due;
        @(negedge clk);
        for (int p = 0; p < NR; p++) begin
            req[p] = rq_act[p]; we[p] = rq_we[p]; addr[p] = rq_addr[p];
            be[p] = rq_be[p]; wdata[p] = rq_wd[p];
        end
        mem_gnt_i    = ($urandom_range(0, 99) < gnt_pct);
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom();
        rv_q = 1'b0;
        if (s_q.size() > 0 && s_q[0].due <= cyc) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = s_q[0].data; rv_q = 1'b1;
        end else if (spurious) begin
            mem_rvalid_i = 1'b1;
        end
        #1;
        // Who should own the SRAM this cycle
        cand = -1;
        if (m_locked) cand = m_lock;
        else begin
            for (int p = 0; p < NR; p++) if (rq_act[p] && m_wait[p] >= MW) begin cand = p; break; end
            if (cand < 0) for (int p = 0; p < NR; p++) if (rq_act[p]) begin cand = p; break; end
        end
        full    = (m_out >= MO);
        ex_mreq = (cand >= 0) && !full;
        ex_gnt  = '0;
        if (ex_mreq && mem_gnt_i) ex_gnt[cand] = 1'b1;
        chk("gnt_o", 64'(gnt_o), 64'(ex_gnt));
        chk("mem_req_o", 64'(mem_req_o), 64'(ex_mreq));
        chk("err_o", 64'(err_o), 64'(m_err));
        if (ex_mreq) begin
            chk("mem_addr_o", 64'(mem_addr_o), 64'(rq_addr[cand]));
            chk("mem_we_o", 64'(mem_we_o), 64'(rq_we[cand]));
        end
        if (!mem_rvalid_i) chk("rdata_o idle", 64'(rdata_o), 64'(0));
        g_hist.push_back(gnt_o);
        if (ex_gnt != '0) begin
            old = m_img.exists(rq_addr[cand]) ? m_img[rq_addr[cand]] : dflt(rq_addr[cand]);
            if (rq_we[cand]) begin
                m_img[rq_addr[cand]] = merge(old, rq_wd[cand], rq_be[cand]);
                d = '0;
            end else d = old;
            exp_q.push_back('{cand, d});
        end
        hs = mem_req_o & mem_gnt_i;
        hs_we = mem_we_o; hs_addr = mem_addr_o; hs_be = mem_be_o; hs_wd = mem_wdata_o;
        rv = mem_rvalid_i;
        @(posedge clk);
        // Model update
        if (rv) begin
            if (m_out == 0) m_err = 1'b1;
            else m_out--;
        end
        if (ex_gnt != '0) m_out++;
        for (int p = 0; p < NR; p++) begin
            if (ex_gnt[p]) m_wait[p] = 0;
            else if (rq_act[p] && m_wait[p] < MW) m_wait[p]++;
        end
        if (!m_locked && ex_mreq && !mem_gnt_i) begin m_locked = 1'b1; m_lock = cand; end
        else if (m_locked && mem_gnt_i) m_locked = 1'b0;
        for (int p = 0; p < NR; p++) begin
            if (ex_gnt[p]) rq_act[p] = 1'b0;
            if (!rq_act[p] && $urandom_range(0, 99) < req_pct) issue_rand(p);
        end
        // SRAM environment: answer accepted commands in order after a delay
        if (rv_q) void'(s_q.pop_front());
        spurious = 1'b0;
        if (hs) begin
            old = s_img.exists(hs_addr) ? s_img[hs_addr] : dflt(hs_addr);
            if (hs_we) begin s_img[hs_addr] = merge(old, hs_wd, hs_be); d = '0; end
            else d = old;
            due = cyc + $urandom_range(dly_min, dly_max);
            if (s_q.size() > 0 && s_q[s_q.size()-1].due >= due) due = s_q[s_q.size()-1].due + 1;
            s_q.push_back('{due, d});
        end
        cyc++;
    endtask

    // Response monitor: every routed response must match the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (mon_en && (mem_rvalid_i || (rvalid_o != '0))) begin
            if (exp_q.size() == 0) begin
                chk("rvalid_o unexpected", 64'(rvalid_o), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("rvalid_o owner", 64'(rvalid_o), 64'(1) << e.port);
                chk("rdata_o", 64'(rdata_o), 64'(e.data));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        mon_en = 1'b0;
        mem_rvalid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst gnt_o", 64'(gnt_o), 64'(0));
        chk("rst rvalid_o", 64'(rvalid_o), 64'(0));
        chk("rst rdata_o", 64'(rdata_o), 64'(0));
        chk("rst mem_req_o", 64'(mem_req_o), 64'(0));
        chk("rst mem_we_o", 64'(mem_we_o), 64'(0));
        chk("rst mem_addr_o", 64'(mem_addr_o), 64'(0));
        chk("rst mem_be_o", 64'(mem_be_o), 64'(0));
        chk("rst mem_wdata_o", 64'(mem_wdata_o), 64'(0));
        chk("rst err_o", 64'(err_o), 64'(0));
        for (int p = 0; p < NR; p++) begin m_wait[p] = 0; rq_act[p] = 1'b0; end
        m_locked = 1'b0; m_lock = 0; m_out = 0; m_err = 1'b0;
        exp_q.delete(); s_q.delete(); spurious = 1'b0;
        req = '0; mem_gnt_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic drain(input int n);
        req_pct = 0; gnt_pct = 100;
        repeat (n) step();
    endtask

    initial begin
        for (int p = 0; p < NR; p++) begin
            rq_act[p] = 1'b0; rq_we[p] = 1'b0; rq_addr[p] = '0; rq_be[p] = '0; rq_wd[p] = '0;
        end
        m_img[32'h10] = 32'hDEAD_BEEF;
        s_img[32'h10] = 32'hDEAD_BEEF;
        do_reset();

        // Single port-0 read, immediate grant, response one cycle later
        req_pct = 0; gnt_pct = 100; dly_min = 1; dly_max = 1;
        g_hist.delete();
        issue(0, 1'b0, 32'h10, 4'hF, '0);
        repeat (3) step();
        chk("single read gnt", 64'(g_hist[0]), 64'(2'b01));

        // Both ports saturating: port 1 starves for MAX_WAIT cycles, then wins once
        g_hist.delete();
        issue_rand(0); issue_rand(1);
        req_pct = 100;
        repeat (12) step();
        for (int k = 0; k < 8; k++) chk("fair p0 streak", 64'(g_hist[k]), 64'(2'b01));
        chk("starved p1 grant", 64'(g_hist[8]), 64'(2'b10));
        chk("p0 resumes", 64'(g_hist[9]), 64'(2'b01));
        drain(6);

        // Lock: port 1 stalled by the SRAM, port 0 arrives but must wait
        g_hist.delete();
        gnt_pct = 0;
        issue(1, 1'b0, 32'h40, 4'hF, '0);
        step();
        issue(0, 1'b0, 32'h80, 4'hF, '0);
        step(); step();
        chk("locked addr", 64'(mem_addr_o), 64'(32'h40));
        gnt_pct = 100;
        step(); step();
        chk("lock grant p1", 64'(g_hist[3]), 64'(2'b10));
        chk("then p0", 64'(g_hist[4]), 64'(2'b01));
        drain(6);

        // Slow responses: third grant blocked until the first response
        g_hist.delete();
        dly_min = 2; dly_max = 2;
        issue_rand(0); issue_rand(1);
        req_pct = 100;
        repeat (10) step();
        chk("fifo full blocks", 64'(g_hist[2]), 64'(0));
        drain(10);

        // Spurious response: sticky error, nothing routed
        spurious = 1'b1;
        step();
        repeat (3) step();
        chk("err sticky", 64'(err_o), 64'(1));

        // Reset with two outstanding, then a fresh transaction
        dly_min = 3; dly_max = 3;
        issue_rand(0); step();
        issue_rand(1); step();
        do_reset();
        dly_min = 1; dly_max = 1;
        issue(1, 1'b0, 32'h10, 4'hF, '0);
        repeat (3) step();

        // Randomized traffic
        req_pct = 40; gnt_pct = 70; dly_min = 1; dly_max = 4;
        repeat (3000) step();
        drain(30);
        chk("scoreboard drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
